// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - shared constants and FSM state type for the operand dispatcher
package dispatch_pkg;
  localparam int DEFAULT_W     = 32;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;
endpackage

// File: rtl/op_fifo.sv
// rtl/op_fifo.sv - operand pair FIFO, power-of-two depth with wrapping pointers
module op_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    // Simultaneous push and pop leaves occupancy unchanged.
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/operand_dispatcher.sv
// rtl/operand_dispatcher.sv - queues operand pairs and launches them one at a time to a compute unit
module operand_dispatcher
  import dispatch_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_a,
  input  logic [W-1:0]             in_b,
  output logic                     start,
  output logic [W-1:0]             i1,
  output logic [W-1:0]             i2,
  input  logic [W-1:0]             result,
  input  logic                     done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);
  state_e         state_q, state_d;
  logic [W-1:0]   i1_q, i1_d;
  logic [W-1:0]   i2_q, i2_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [2*W-1:0] fifo_head;

  op_fifo #(
    .DW    (2 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid && in_ready),
    .push_data ({in_a, in_b}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  assign in_ready  = !fifo_full;
  assign start     = (state_q == ST_ISSUE);
  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q != ST_IDLE);
  assign i1        = i1_q;
  assign i2        = i2_q;
  assign out_data  = out_data_q;

  // done is only honoured in WAIT; every other state ignores it.
  always_comb begin
    state_d    = state_q;
    i1_d       = i1_q;
    i2_d       = i2_q;
    out_data_d = out_data_q;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          i1_d     = fifo_head[2*W-1:W];
          i2_d     = fifo_head[W-1:0];
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (done) begin
          out_data_d = result;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      i1_q       <= '0;
      i2_q       <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      i1_q       <= i1_d;
      i2_q       <= i2_d;
      out_data_q <= out_data_d;
    end
  end
endmodule

// File: tb/tb_operand_dispatcher.sv
// tb/tb_operand_dispatcher.sv - directed self-checking bench for operand_dispatcher
module tb_operand_dispatcher;
  localparam int W     = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          start;
  logic [W-1:0]  i1, i2;
  logic [W-1:0]  result;
  logic          done;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [2:0]    count;
  logic          busy;

  logic          tb_done = 1'b0;
  logic [W-1:0]  tb_res = '0;
  logic          m_done = 1'b0;
  logic [W-1:0]  m_res = '0;
  logic          model_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  assign done   = tb_done | m_done;
  assign result = tb_done ? tb_res : m_res;

  always #5 clk = ~clk;

  operand_dispatcher #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .start     (start),
    .i1        (i1),
    .i2        (i2),
    .result    (result),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .busy      (busy)
  );

  // Compute-unit model: result = i1 + i2, done a few cycles after start.
  initial begin : compute_model
    logic [W-1:0] sum;
    forever begin
      @(negedge clk);
      if (model_en && start) begin
        sum = i1 + i2;
        repeat (3) @(negedge clk);
        m_res  = sum;
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
      end
    end
  end

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t >= 50) begin
      n_fail++;
      $display("FAIL push_timeout: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0b expected 1", in_ready); end
    n_checks++; if (busy !== 1'b0 || start !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_ctrl: busy=%0b start=%0b out_valid=%0b expected 0 0 0", busy, start, out_valid);
    end
    n_checks++; if (i1 !== '0 || i2 !== '0 || out_data !== '0) begin
      n_fail++; $display("FAIL rst_data: i1=%0d i2=%0d out_data=%0d expected 0 0 0", i1, i2, out_data);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %0b expected 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_a = W'(i + 1);
      in_b = W'(i + 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (count !== 3'd3 || busy !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_state: count=%0d busy=%0b expected 3 1", count, busy);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL midrst_count: got %0d expected 0", count); end
    n_checks++; if (busy !== 1'b0 || start !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_ctrl: busy=%0b start=%0b out_valid=%0b in_ready=%0b expected 0 0 0 1",
                         busy, start, out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int starts;
    bit got;
    model_en = 1'b1;
    push(10, 5);
    starts = 0;
    got = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      if (start) begin
        starts++;
        if (starts == 1) begin
          n_checks++; if (i1 !== 10 || i2 !== 5) begin
            n_fail++; $display("FAIL single_operands: i1=%0d i2=%0d expected 10 5", i1, i2);
          end
        end
      end
      if (out_valid && !got) begin
        got = 1;
        n_checks++; if (out_data !== 15) begin n_fail++; $display("FAIL single_result: got %0d expected 15", out_data); end
        out_ready = 1'b1;
      end
    end
    out_ready = 1'b0;
    n_checks++; if (starts != 1) begin n_fail++; $display("FAIL single_starts: got %0d expected 1", starts); end
    n_checks++; if (!got) begin n_fail++; $display("FAIL single_out_valid: got 0 expected 1"); end
  endtask

  task automatic test_full();
    bit blocked_ok;
    bit seen;
    int idx;
    logic [W-1:0] exp_full [5];
    exp_full[0] = 23; exp_full[1] = 27; exp_full[2] = 31; exp_full[3] = 35; exp_full[4] = 121;
    model_en = 1'b0;
    out_ready = 1'b0;
    push(100, 1);
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b1 || count !== 3'd0) begin
      n_fail++; $display("FAIL full_inflight: busy=%0b count=%0d expected 1 0", busy, count);
    end
    push(11, 12);
    push(13, 14);
    push(15, 16);
    push(17, 18);
    n_checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_reached: count=%0d in_ready=%0b expected 4 0", count, in_ready);
    end
    in_valid = 1'b1;
    in_a = 55;
    in_b = 66;
    blocked_ok = 1;
    repeat (5) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || count !== 3'd4) blocked_ok = 0;
    end
    n_checks++; if (!blocked_ok) begin n_fail++; $display("FAIL full_blocked: count=%0d in_ready=%0b expected 4 0", count, in_ready); end
    model_en = 1'b1;
    tb_res = 77;
    tb_done = 1'b1;
    @(negedge clk);
    tb_done = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 77) begin
      n_fail++; $display("FAIL full_first_result: out_valid=%0b out_data=%0d expected 1 77", out_valid, out_data);
    end
    out_ready = 1'b1;
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (in_ready) seen = 1;
    end
    n_checks++; if (!seen || count !== 3'd3) begin
      n_fail++; $display("FAIL full_pop_frees: in_ready=%0b count=%0d expected 1 3", in_ready, count);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_fifth_accepted: count=%0d expected 4", count); end
    idx = 0;
    for (int t = 0; t < 300 && !(idx == 5 && !busy); t++) begin
      if (out_valid && out_ready && idx < 5) begin
        n_checks++; if (out_data !== exp_full[idx]) begin
          n_fail++; $display("FAIL full_order[%0d]: got %0d expected %0d", idx, out_data, exp_full[idx]);
        end
        idx++;
      end
      @(negedge clk);
    end
    n_checks++; if (idx != 5 || busy !== 1'b0 || count !== 3'd0) begin
      n_fail++; $display("FAIL full_drain: results=%0d busy=%0b count=%0d expected 5 0 0", idx, busy, count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_ordering();
    int idx;
    logic [W-1:0] exp_ord [3];
    exp_ord[0] = 3; exp_ord[1] = 7; exp_ord[2] = 11;
    model_en = 1'b1;
    out_ready = 1'b1;
    push(1, 2);
    push(3, 4);
    push(5, 6);
    idx = 0;
    for (int t = 0; t < 100 && idx < 3; t++) begin
      @(negedge clk);
      if (out_valid) begin
        n_checks++; if (out_data !== exp_ord[idx]) begin
          n_fail++; $display("FAIL order[%0d]: got %0d expected %0d", idx, out_data, exp_ord[idx]);
        end
        idx++;
      end
    end
    n_checks++; if (idx != 3) begin n_fail++; $display("FAIL order_count: got %0d results expected 3", idx); end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit stable_ok, nostart_ok, seen;
    model_en = 1'b1;
    out_ready = 1'b0;
    push(20, 22);
    seen = 0;
    for (int t = 0; t < 30 && !seen; t++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL bp_wait_result: out_valid=0 expected 1"); end
    stable_ok = 1;
    nostart_ok = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 2) begin in_valid = 1'b1; in_a = 7; in_b = 8; end
      if (c == 3) in_valid = 1'b0;
      if (c == 5) begin tb_res = 0; tb_done = 1'b1; end
      if (c == 6) tb_done = 1'b0;
      if (out_valid !== 1'b1 || out_data !== 42) stable_ok = 0;
      if (start !== 1'b0) nostart_ok = 0;
    end
    n_checks++; if (!stable_ok) begin n_fail++; $display("FAIL bp_stable: out_valid=%0b out_data=%0d expected 1 42", out_valid, out_data); end
    n_checks++; if (!nostart_ok) begin n_fail++; $display("FAIL bp_no_start: start seen expected none"); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL bp_accepting: count=%0d expected 1", count); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (start !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_idle_cycle: start=%0b out_valid=%0b expected 0 0", start, out_valid);
    end
    @(negedge clk);
    n_checks++; if (start !== 1'b1 || i1 !== 7 || i2 !== 8) begin
      n_fail++; $display("FAIL bp_relaunch: start=%0b i1=%0d i2=%0d expected 1 7 8", start, i1, i2);
    end
    seen = 0;
    for (int t = 0; t < 30 && !seen; t++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    n_checks++; if (!seen || out_data !== 15) begin
      n_fail++; $display("FAIL bp_second_result: out_valid=%0b out_data=%0d expected 1 15", out_valid, out_data);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_spurious_done();
    model_en = 1'b0;
    tb_res = 99;
    tb_done = 1'b1;
    @(negedge clk);
    tb_done = 1'b0;
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 15) begin
      n_fail++; $display("FAIL spur_idle: busy=%0b out_valid=%0b out_data=%0d expected 0 0 15", busy, out_valid, out_data);
    end
    push(2, 3);
    tb_res = 99;
    tb_done = 1'b1;
    @(negedge clk);
    n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL spur_issue_start: got %0b expected 1", start); end
    @(negedge clk);
    tb_done = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b1 || start !== 1'b0 || out_data !== 15) begin
      n_fail++; $display("FAIL spur_issue: out_valid=%0b busy=%0b start=%0b out_data=%0d expected 0 1 0 15",
                         out_valid, busy, start, out_data);
    end
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL spur_wait_stays: out_valid=%0b busy=%0b expected 0 1", out_valid, busy);
    end
    tb_res = 5;
    tb_done = 1'b1;
    @(negedge clk);
    tb_done = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 5) begin
      n_fail++; $display("FAIL spur_real_done: out_valid=%0b out_data=%0d expected 1 5", out_valid, out_data);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL spur_back_idle: busy=%0b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_ordering();
    test_backpressure();
    test_spurious_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/operand_dispatcher.md
OPERAND_DISPATCHER -- requirements
Module: operand_dispatcher

Interface
REQ-001 SHALL have parameter W, default 32, meaning operand and result width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning operand FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, an operand pair is offered.
REQ-006 SHALL have port in_ready, output, 1, FIFO not full.
REQ-007 SHALL have ports in_a and in_b, input, W each, the operand pair.
REQ-008 SHALL have port start, output, 1, one-cycle launch pulse to the compute unit.
REQ-009 SHALL have ports i1 and i2, output, W each, registered operands to the compute unit.
REQ-010 SHALL have port result, input, W, the compute unit result.
REQ-011 SHALL have port done, input, 1, the compute unit completion flag.
REQ-012 SHALL have port out_valid, output, 1, a captured result is available.
REQ-013 SHALL have port out_ready, input, 1, the consumer accepts the result.
REQ-014 SHALL have port out_data, output, W, the captured result.
REQ-015 SHALL have port count, output, $clog2(DEPTH)+1, FIFO occupancy.
REQ-016 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-017 SHALL push {in_a,in_b} when in_valid&&in_ready; in_ready = (count<DEPTH), combinational from count only.
REQ-018 SHALL use FIFO pointers that wrap modulo DEPTH; a push while full SHALL be impossible because in_ready=0.
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, HOLD.
REQ-020 IDLE: if count>0, SHALL go to ISSUE next cycle, latching the FIFO head into i1/i2 and popping it.
REQ-021 ISSUE: SHALL assert start for exactly one cycle, then go to WAIT; done SHALL be ignored in ISSUE.
REQ-022 WAIT: on done=1, SHALL capture result into out_data and go to HOLD; otherwise SHALL stay in WAIT indefinitely.
REQ-023 HOLD: SHALL assert out_valid; on out_ready=1, SHALL go to IDLE; out_data SHALL stay stable while out_valid=1.
REQ-024 SHALL hold i1/i2 stable from ISSUE until the next launch.
REQ-025 SHALL reach the next start 3 cycles after the HOLD handshake when the FIFO is non-empty (HOLD, IDLE, ISSUE).
REQ-026 Simultaneous push and pop in the IDLE-to-ISSUE cycle SHALL leave count unchanged; a push into an empty FIFO SHALL NOT be popped in the same cycle.
REQ-027 SHALL ignore done in IDLE, ISSUE and HOLD; no capture, no state change.
REQ-028 SHALL give the first pair the first launch; result order SHALL equal push order.

Reset
REQ-029 rst=0 SHALL asynchronously force state=IDLE, pointers=0, count=0, start=0, out_valid=0, busy=0, i1=i2=out_data=0.
REQ-030 SHALL make in_ready=1 while reset is asserted and after it is released.
REQ-031 Reset mid-operation SHALL discard the FIFO contents and any in-flight result.

Structure
REQ-032 SHALL place the FSM state enum and the default W/DEPTH constants in shared package dispatch_pkg.
REQ-033 SHALL implement the FIFO as sub-module op_fifo, with push/pop/full/empty/count ports.

Verification
REQ-034 Reset: rst=0 mid-WAIT with 3 entries queued -> count=0, start=0, out_valid=0, busy=0 immediately.
REQ-035 Single op: push (10,5), model done 4 cycles after start with result 15 -> one start pulse, i1=10, i2=5, out_data=15 with out_valid.
REQ-036 Full: push 5 pairs back-to-back with done held off -> in_ready=0 after count reaches 4; fifth pair accepted only after the first pop.
REQ-037 Ordering: push (1,2),(3,4),(5,6), model done with result=i1+i2 -> outputs 3, 7, 11 in order.
REQ-038 Backpressure: out_ready=0 for 10 cycles in HOLD -> out_data stable, no new start, FIFO still accepting pushes.
REQ-039 Spurious done: done=1 pulses in IDLE and ISSUE -> no capture, no state change.
